// File: rtl/parity_frame_checker.sv
// Serial parity frame checker: deserialises DATA_BITS data bits (LSB first) plus one
// parity bit, checks even/odd parity per frame and keeps a saturating error count.
module parity_frame_checker #(
  parameter int DATA_BITS = 8,
  parameter int ODD_MODE  = 0,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 sync_clr,
  input  logic                 cnt_clr,
  output logic                 busy,
  output logic                 is_odd,
  output logic                 frame_done,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BITS - 1);
  localparam logic ODD_BIT = (ODD_MODE != 0);

  // Handshake: a bit is consumed on any rising edge where bit_valid=1 and sync_clr=0;
  // there is no backpressure, the source may insert gaps of any length between bits.
  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [DATA_BITS-1:0]   shreg, shreg_n;
  logic                   odd_n, done_n, perr_n, err;
  logic [DATA_BITS-1:0]   dout_n;
  logic [ERR_CNT_W-1:0]   errc_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      is_odd     <= 1'b0;
      frame_done <= 1'b0;
      data_out   <= '0;
      parity_err <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shreg      <= shreg_n;
      is_odd     <= odd_n;
      frame_done <= done_n;
      data_out   <= dout_n;
      parity_err <= perr_n;
      err_count  <= errc_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    odd_n   = is_odd;
    done_n  = 1'b0;
    dout_n  = data_out;
    perr_n  = parity_err;
    errc_n  = err_count;
    err     = 1'b0;
    if (sync_clr) begin
      // Abort drops any partial word; the results of the last good frame stay visible.
      state_n = IDLE;
      cnt_n   = '0;
      odd_n   = 1'b0;
      shreg_n = '0;
    end else if (bit_valid) begin
      case (state)
        IDLE: begin
          shreg_n    = '0;
          shreg_n[0] = bit_in;
          odd_n      = bit_in;
          cnt_n      = CNT_W'(1);
          state_n    = (DATA_BITS == 1) ? PARITY : DATA;
        end
        DATA: begin
          for (int i = 0; i < DATA_BITS; i++) begin
            if (cnt == CNT_W'(i)) shreg_n[i] = bit_in;
          end
          odd_n = is_odd ^ bit_in;
          cnt_n = cnt + 1'b1;
          if (cnt == LAST_IDX) state_n = PARITY;
        end
        PARITY: begin
          err    = (bit_in != (is_odd ^ ODD_BIT));
          done_n = 1'b1;
          dout_n = shreg;
          perr_n = err;
          if (err && (err_count != '1)) errc_n = err_count + 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
          odd_n   = 1'b0;
        end
        default: state_n = IDLE;
      endcase
    end
    if (cnt_clr) errc_n = '0;
  end

  assign busy = (state != IDLE);

endmodule
